// File: rtl/case_9_mul_rr_sched.sv
// Round-robin scheduler sharing one signed truncating multiplier among NUM_REQ
// requesters; results come back in order, tagged with the requester id.
module case_9_mul_rr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 8,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 8,
    parameter int MUL_STAGES = 1
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic                             busy
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    logic                                    adv;
    logic                                    fire;
    logic [NUM_REQ-1:0]                      hi_mask;
    logic [NUM_REQ-1:0]                      sel_mask;
    logic [NUM_REQ-1:0]                      grant;
    logic [ID_WIDTH-1:0]                     grant_id;
    logic [ID_WIDTH-1:0]                     ptr_q, ptr_d;
    logic [DIN0_WIDTH-1:0]                   din0_sel;
    logic [DIN1_WIDTH-1:0]                   din1_sel;
    logic [PROD_WIDTH-1:0]                   a_ext, b_ext, prod;
    logic [DOUT_WIDTH-1:0]                   prod_trunc;
    logic [MUL_STAGES-1:0]                   stage_valid;
    logic [MUL_STAGES-1:0][ID_WIDTH-1:0]     stage_id;
    logic [MUL_STAGES-1:0][DOUT_WIDTH-1:0]   stage_data;

    assign rsp_valid = stage_valid[MUL_STAGES-1];
    assign rsp_id    = stage_id[MUL_STAGES-1];
    assign rsp_dout  = stage_data[MUL_STAGES-1];
    assign busy      = |stage_valid;
    assign adv       = !rsp_valid || rsp_ready;
    assign fire      = adv && (|req_valid);
    assign req_ready = adv ? grant : '0;

    // Rotating priority: requesters at or above ptr win first, otherwise wrap to the lowest index.
    always_comb begin
        hi_mask = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            hi_mask[j] = req_valid[j] && (j >= int'(ptr_q));
        end
        sel_mask = (hi_mask != '0) ? hi_mask : req_valid;
        grant    = '0;
        grant_id = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (sel_mask[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                grant_id = ID_WIDTH'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        din0_sel = '0;
        din1_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant[j]) begin
                din0_sel = req_din0[j*DIN0_WIDTH +: DIN0_WIDTH];
                din1_sel = req_din1[j*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Both operands sign-extended to the full product width, so the low bits are the signed product.
    assign a_ext      = {{DIN1_WIDTH{din0_sel[DIN0_WIDTH-1]}}, din0_sel};
    assign b_ext      = {{DIN0_WIDTH{din1_sel[DIN1_WIDTH-1]}}, din1_sel};
    assign prod       = a_ext * b_ext;
    assign prod_trunc = prod[DOUT_WIDTH-1:0];

    for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
        logic                  valid_q, valid_d;
        logic [ID_WIDTH-1:0]   id_q, id_d;
        logic [DOUT_WIDTH-1:0] data_q, data_d;

        if (gi == 0) begin : g_head
            always_comb begin
                valid_d = valid_q;
                id_d    = id_q;
                data_d  = data_q;
                if (adv) begin
                    valid_d = fire;
                    id_d    = grant_id;
                    data_d  = prod_trunc;
                end
            end
        end else begin : g_tail
            always_comb begin
                valid_d = valid_q;
                id_d    = id_q;
                data_d  = data_q;
                if (adv) begin
                    valid_d = stage_valid[gi-1];
                    id_d    = stage_id[gi-1];
                    data_d  = stage_data[gi-1];
                end
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                valid_q <= 1'b0;
                id_q    <= '0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                id_q    <= id_d;
                data_q  <= data_d;
            end
        end

        assign stage_valid[gi] = valid_q;
        assign stage_id[gi]    = id_q;
        assign stage_data[gi]  = data_q;
    end

endmodule

// File: tb/tb_case_9_mul_rr_sched.sv
// Drives three schedulers (MUL_STAGES = 1, 2, 3) with shared stimulus and checks each
// against a reference arbiter and an in-order scoreboard with stall-aware latency.
module tb_case_9_mul_rr_sched;

    localparam int NR = 4;
    localparam int NS = 3;

    typedef struct {
        int         id;
        logic [7:0] dout;
        int         t;
        int         st;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_din0;
    logic [23:0] req_din1;
    logic        rsp_ready;

    logic [3:0]  req_ready_w [NS];
    logic        rsp_valid_w [NS];
    logic [1:0]  rsp_id_w    [NS];
    logic [7:0]  rsp_dout_w  [NS];
    logic        busy_w      [NS];

    exp_t        sb_q [NS][$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cum  [NS];
    int          ptr_m      [NS];
    logic        prev_stall [NS];
    logic [1:0]  prev_id    [NS];
    logic [7:0]  prev_dout  [NS];
    logic        was_rst = 1'b0;

    always #5 ap_clk = ~ap_clk;

    for (genvar gi = 0; gi < NS; gi++) begin : g_dut
        case_9_mul_rr_sched #(.MUL_STAGES(gi + 1)) u_dut (
            .ap_clk    (ap_clk),
            .ap_rst    (ap_rst),
            .req_valid (req_valid),
            .req_ready (req_ready_w[gi]),
            .req_din0  (req_din0),
            .req_din1  (req_din1),
            .rsp_valid (rsp_valid_w[gi]),
            .rsp_ready (rsp_ready),
            .rsp_id    (rsp_id_w[gi]),
            .rsp_dout  (rsp_dout_w[gi]),
            .busy      (busy_w[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mul_ref(input logic [7:0] a, input logic [5:0] b);
        int pa;
        int pb;
        int p;
        pa = $signed(a);
        pb = $signed(b);
        p  = pa * pb;
        return p[7:0];
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle when inputs and outputs are stable.
    always @(negedge ap_clk) begin : mon
        logic        exp_valid;
        logic        adv_m;
        logic        stall;
        logic [3:0]  exp_ready;
        logic [31:0] d0;
        logic [23:0] d1;
        int          age;
        int          gid;
        int          j;
        exp_t        e;
        exp_t        ne;
        for (int g = 0; g < NS; g++) begin
            if (ap_rst) begin
                sb_q[g].delete();
                ptr_m[g]      = 0;
                stall_cum[g]  = 0;
                prev_stall[g] = 1'b0;
            end else begin
                if (was_rst) begin
                    chk($sformatf("s%0d_rst_rsp_valid", g + 1), 32'(rsp_valid_w[g]), 0);
                    chk($sformatf("s%0d_rst_busy", g + 1), 32'(busy_w[g]), 0);
                    chk($sformatf("s%0d_rst_rsp_id", g + 1), 32'(rsp_id_w[g]), 0);
                    chk($sformatf("s%0d_rst_rsp_dout", g + 1), 32'(rsp_dout_w[g]), 0);
                end
                exp_valid = 1'b0;
                if (sb_q[g].size() > 0) begin
                    e         = sb_q[g][0];
                    age       = cyc - e.t - (stall_cum[g] - e.st);
                    exp_valid = (age >= g + 1);
                end
                chk($sformatf("s%0d_rsp_valid", g + 1), 32'(rsp_valid_w[g]), 32'(exp_valid));
                chk($sformatf("s%0d_busy", g + 1), 32'(busy_w[g]), 32'(sb_q[g].size() > 0));
                if (exp_valid && rsp_valid_w[g]) begin
                    chk($sformatf("s%0d_rsp_id", g + 1), 32'(rsp_id_w[g]), 32'(e.id));
                    chk($sformatf("s%0d_rsp_dout", g + 1), 32'(rsp_dout_w[g]), 32'(e.dout));
                end
                if (prev_stall[g]) begin
                    chk($sformatf("s%0d_hold_id", g + 1), 32'(rsp_id_w[g]), 32'(prev_id[g]));
                    chk($sformatf("s%0d_hold_dout", g + 1), 32'(rsp_dout_w[g]), 32'(prev_dout[g]));
                end
                adv_m = !exp_valid || rsp_ready;
                gid   = -1;
                for (int k = 0; k < NR; k++) begin
                    j = (ptr_m[g] + k) % NR;
                    if (gid < 0 && req_valid[j]) gid = j;
                end
                exp_ready = (adv_m && gid >= 0) ? (4'b0001 << gid) : 4'b0000;
                chk($sformatf("s%0d_req_ready", g + 1), 32'(req_ready_w[g]), 32'(exp_ready));
                stall = exp_valid && !rsp_ready;
                if (stall) stall_cum[g]++;
                prev_stall[g] = stall;
                prev_id[g]    = rsp_id_w[g];
                prev_dout[g]  = rsp_dout_w[g];
                if (exp_valid && rsp_ready) begin
                    e = sb_q[g].pop_front();
                    $display("rsp s%0d id=%0d dout=%02h accepted@%0d popped@%0d", g + 1, e.id, e.dout, e.t, cyc);
                end
                if (adv_m && gid >= 0) begin
                    d0      = req_din0 >> (gid * 8);
                    d1      = req_din1 >> (gid * 6);
                    ne.id   = gid;
                    ne.dout = mul_ref(d0[7:0], d1[5:0]);
                    ne.t    = cyc;
                    ne.st   = stall_cum[g];
                    sb_q[g].push_back(ne);
                    ptr_m[g] = (gid + 1) % NR;
                end
            end
        end
        was_rst = ap_rst;
        cyc++;
    end

    task automatic step(input logic [3:0] v, input logic rr);
        logic [31:0] r0;
        logic [31:0] r1;
        @(posedge ap_clk);
        #1;
        r0        = $urandom;
        r1        = $urandom;
        req_valid = v;
        rsp_ready = rr;
        req_din0  = r0;
        req_din1  = r1[23:0];
    endtask

    task automatic op_one(input logic [7:0] a, input logic [5:0] b, input logic [7:0] expd);
        @(posedge ap_clk);
        #1;
        req_valid = 4'b0010;
        req_din0  = 32'(a) << 8;
        req_din1  = 24'(b) << 6;
        @(posedge ap_clk);
        #1;
        req_valid = 4'b0000;
        @(negedge ap_clk);
        chk("t2_dout_s1", 32'(rsp_dout_w[0]), 32'(expd));
    endtask

    initial begin
        int left;
        ap_rst    = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        // single op from requester 0
        @(posedge ap_clk);
        #1;
        req_valid = 4'b0001;
        req_din0  = 32'h0000_007F;
        req_din1  = 24'h00_001F;
        @(negedge ap_clk);
        for (int g = 0; g < NS; g++) chk("t1_req_ready", 32'(req_ready_w[g]), 32'h1);
        @(posedge ap_clk);
        #1 req_valid = 4'b0000;
        @(negedge ap_clk);
        chk("t1_rsp_valid_s1", 32'(rsp_valid_w[0]), 1);
        chk("t1_rsp_id_s1", 32'(rsp_id_w[0]), 0);
        chk("t1_rsp_dout_s1", 32'(rsp_dout_w[0]), 32'h61);
        repeat (3) step(4'b0000, 1'b1);

        // signed truncation corners
        op_one(8'hFD, 6'h05, 8'hF1);
        op_one(8'h80, 6'h20, 8'h00);
        op_one(8'h80, 6'h1F, 8'h80);
        repeat (3) step(4'b0000, 1'b1);

        // fairness with all requesters active
        repeat (12) step(4'b1111, 1'b1);

        // backpressure on a full pipeline, then drain
        repeat (4) step(4'b1111, 1'b1);
        repeat (4) step(4'b1111, 1'b0);
        repeat (6) step(4'b0000, 1'b1);

        // a lone requester is granted every cycle
        repeat (6) step(4'b0100, 1'b1);
        repeat (3) step(4'b0000, 1'b1);

        // reset with work in flight and ptr at 2
        @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        repeat (2) step(4'b0011, 1'b1);
        @(posedge ap_clk);
        #1;
        ap_rst    = 1'b1;
        req_valid = 4'b0000;
        @(posedge ap_clk);
        #1;
        ap_rst    = 1'b0;
        req_valid = 4'b0101;
        @(negedge ap_clk);
        for (int g = 0; g < NS; g++) chk("t5_first_grant", 32'(req_ready_w[g]), 32'h1);
        repeat (4) step(4'b0101, 1'b1);

        // random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end

        // drain everything still in flight
        left = 1;
        for (int i = 0; i < 30 && left != 0; i++) begin
            step(4'b0000, 1'b1);
            @(negedge ap_clk);
            left = sb_q[0].size() + sb_q[1].size() + sb_q[2].size();
        end
        chk("drain_left", 32'(left), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
